i2c_byte_transceiver: RTL

Parametrised bit-level I2C master engine that shifts one data word out or in over open-drain SDA/SCL and then handles the acknowledge bit.
- Write mode: sends the word, then samples ACK.
- Read mode: receives the word, then drives ACK or NACK.
- Detects clock-stretch timeout and arbitration loss.
- Sits below the transaction sequencer, which issues START/STOP and one command per word. The block is entered and left with SCL held low.

---
 rtl/i2c_byte_transceiver.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_byte_transceiver.sv
// Bit-level I2C master engine: shifts one word over open-drain SDA/SCL, then handles the ACK slot.
// Entered and left with SCL held low; START/STOP are issued by the sequencer above this block.
module i2c_byte_transceiver #(
    parameter int CLK_DIV         = 125,
    parameter int STRETCH_TIMEOUT = 50000,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 read_mode,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 ack_out,
    input  logic                 sda_in,
    input  logic                 scl_in,
    output logic                 sda_oe,
    output logic                 scl_oe,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 nack,
    output logic                 timeout,
    output logic                 arb_lost
);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int SW = $clog2(STRETCH_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOW1   = 3'd1,
        ST_LOW2   = 3'd2,
        ST_RISE   = 3'd3,
        ST_HIGH   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    state_t               state_q;
    logic [DW-1:0]        div_q;
    logic [SW-1:0]        stretch_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] tx_q;
    logic [DATA_BITS-1:0] rx_q;
    logic                 read_q;
    logic                 ack_out_q;
    logic                 sda_oe_q;
    logic                 scl_oe_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 nack_q;
    logic                 timeout_q;
    logic                 arb_lost_q;

    logic                 div_last_d;
    logic [IW-1:0]        bit_idx_d;
    logic [DATA_BITS-1:0] tx_d;
    logic [DATA_BITS-1:0] rx_d;
    logic                 start_oe_d;
    logic                 next_oe_d;
    logic                 arb_d;

    // bit_idx == 0 is the ACK slot; ack_n = 0 means the master drives ACK (pulls SDA low)
    function automatic logic slot_oe(input logic rd, input logic ack_n, input logic bit_v,
                                     input logic ack_slot);
        logic oe;
        if (ack_slot) begin
            oe = rd ? ~ack_n : 1'b0;
        end else begin
            oe = rd ? 1'b0 : ~bit_v;
        end
        return oe;
    endfunction

    // Next-slot values and the arbitration test for the current write data bit
    always_comb begin
        div_last_d = (div_q == DW'(CLK_DIV - 1));
        bit_idx_d  = bit_idx_q - IW'(1);
        tx_d       = tx_q << 1;
        rx_d       = (rx_q << 1) | DATA_BITS'(sda_in);
        start_oe_d = slot_oe(read_mode, ack_out, tx_data[DATA_BITS-1], 1'b0);
        next_oe_d  = slot_oe(read_q, ack_out_q, tx_d[DATA_BITS-1], bit_idx_d == '0);
        arb_d      = ~read_q && (bit_idx_q != '0) && ~sda_oe_q && ~sda_in;
    end

    // Bit-slot sequencer with registered line enables and status
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            stretch_q  <= '0;
            bit_idx_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            read_q     <= 1'b0;
            ack_out_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            timeout_q  <= 1'b0;
            arb_lost_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    scl_oe_q <= 1'b1;
                    if (start) begin
                        read_q     <= read_mode;
                        ack_out_q  <= ack_out;
                        tx_q       <= tx_data;
                        rx_q       <= '0;
                        bit_idx_q  <= IW'(DATA_BITS);
                        nack_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                        arb_lost_q <= 1'b0;
                        sda_oe_q   <= start_oe_d;
                        busy_q     <= 1'b1;
                        div_q      <= '0;
                        state_q    <= ST_LOW1;
                    end
                end
                ST_LOW1: begin
                    if (div_last_d) begin
                        div_q   <= '0;
                        state_q <= ST_LOW2;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                ST_LOW2: begin
                    if (div_last_d) begin
                        div_q     <= '0;
                        stretch_q <= '0;
                        scl_oe_q  <= 1'b0;
                        state_q   <= ST_RISE;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                ST_RISE: begin
                    // timeout is evaluated here first, so it wins over arbitration
                    if (!scl_in) begin
                        if (stretch_q == SW'(STRETCH_TIMEOUT - 1)) begin
                            timeout_q <= 1'b1;
                            scl_oe_q  <= 1'b1;
                            sda_oe_q  <= 1'b0;
                            state_q   <= ST_FINISH;
                        end else begin
                            stretch_q <= stretch_q + SW'(1);
                        end
                    end else if (div_last_d) begin
                        div_q   <= '0;
                        state_q <= ST_HIGH;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                ST_HIGH: begin
                    if (div_q == '0 && arb_d) begin
                        arb_lost_q <= 1'b1;
                        sda_oe_q   <= 1'b0;
                        state_q    <= ST_FINISH;
                    end else begin
                        if (div_q == '0) begin
                            if (read_q && bit_idx_q != '0) begin
                                rx_q <= rx_d;
                            end
                            if (!read_q && bit_idx_q == '0) begin
                                nack_q <= sda_in;
                            end
                        end
                        if (div_last_d) begin
                            div_q    <= '0;
                            scl_oe_q <= 1'b1;
                            if (bit_idx_q == '0) begin
                                state_q <= ST_FINISH;
                            end else begin
                                bit_idx_q <= bit_idx_d;
                                tx_q      <= tx_d;
                                sda_oe_q  <= next_oe_d;
                                state_q   <= ST_LOW1;
                            end
                        end else begin
                            div_q <= div_q + DW'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    scl_oe_q <= 1'b1;
                    sda_oe_q <= 1'b0;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign scl_oe   = scl_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_q;
    assign nack     = nack_q;
    assign timeout  = timeout_q;
    assign arb_lost = arb_lost_q;
endmodule
